// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/halt/single-step sequencer for the single-cycle MIPS core
//
// Owns the core's reset and per-cycle execute enable. After controller reset the
// core is held in reset for RST_CYCLES edges, then the host can RUN, STEP or HALT
// it. Execution stops on a PC breakpoint (RUN only) or on a BREAK instruction,
// which is never executed. Retired instructions are counted.
//
// Ports:
//   clk_in       system clock, rising edge
//   reset        synchronous active-low reset
//   cmd_valid    host command present
//   cmd_ready    command accepted on valid && ready edge (low in RESET_HOLD)
//   cmd_op       00 RUN, 01 STEP, 10 HALT, 11 SET_BP
//   cmd_arg      STEP: count in [STEP_W-1:0]; SET_BP: [31:2] word addr, [0] enable
//   pc_i         core PC of the instruction about to execute
//   inst_i       core instruction about to execute
//   cpu_rst      active-high reset to the core
//   cpu_en       core commits the current instruction on this edge
//   state_o      0 RESET_HOLD, 1 HALTED, 2 RUN, 3 STEP
//   halt_cause   0 command/none, 1 breakpoint, 2 BREAK, 3 step done
//   step_left    steps remaining while in STEP
//   retired_cnt  number of edges with cpu_en=1, wrapping
module cpu_run_ctrl #(
  parameter int          STEP_W     = 16,
  parameter int          RST_CYCLES = 4,
  parameter int          AUTO_RUN   = 0,
  parameter logic [31:0] BREAK_INST = 32'h0000000D
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_arg,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       inst_i,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic [1:0]        state_o,
  output logic [1:0]        halt_cause,
  output logic [STEP_W-1:0] step_left,
  output logic [31:0]       retired_cnt
);

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_HALTED     = 2'd1,
    S_RUN        = 2'd2,
    S_STEP       = 2'd3
  } state_t;

  localparam logic [1:0] OP_RUN    = 2'b00;
  localparam logic [1:0] OP_STEP   = 2'b01;
  localparam logic [1:0] OP_HALT   = 2'b10;
  localparam logic [1:0] OP_SET_BP = 2'b11;

  localparam logic [1:0] CAUSE_CMD  = 2'd0;
  localparam logic [1:0] CAUSE_BP   = 2'd1;
  localparam logic [1:0] CAUSE_BRK  = 2'd2;
  localparam logic [1:0] CAUSE_STEP = 2'd3;

  localparam int                HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [29:0]         bp_addr;
  logic                bp_en;

  logic                hit_bp;
  logic                hit_brk;
  logic                cmd_fire;
  logic [STEP_W-1:0]   step_arg;
  logic                unused_bits;

  assign hit_bp    = bp_en && (pc_i[31:2] == bp_addr);
  assign hit_brk   = (inst_i == BREAK_INST);
  assign cmd_ready = (state != S_RESET_HOLD);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign step_arg  = cmd_arg[STEP_W-1:0];
  assign state_o   = state;

  // Byte-offset bits never participate in breakpoint matching.
  assign unused_bits = ^{cmd_arg[1], pc_i[1:0]};

  // The core samples cpu_en on the same edge it would commit, so this stays
  // combinational from the current PC/instruction. Breakpoints only gate RUN so
  // the host can step off an instruction it stopped on.
  always_comb begin
    cpu_en = 1'b0;
    case (state)
      S_RUN:   cpu_en = !hit_bp && !hit_brk;
      S_STEP:  cpu_en = (step_left != '0) && !hit_brk;
      default: cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state       <= S_RESET_HOLD;
      cpu_rst     <= 1'b1;
      halt_cause  <= CAUSE_CMD;
      step_left   <= '0;
      retired_cnt <= '0;
      bp_addr     <= '0;
      bp_en       <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      if (cpu_en) begin
        retired_cnt <= retired_cnt + 32'd1;
      end

      // cmd_fire is never true in RESET_HOLD, so this covers HALTED/RUN/STEP.
      if (cmd_fire && (cmd_op == OP_SET_BP)) begin
        bp_addr <= cmd_arg[31:2];
        bp_en   <= cmd_arg[0];
      end

      case (state)
        S_RESET_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state   <= (AUTO_RUN != 0) ? S_RUN : S_HALTED;
            cpu_rst <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        S_HALTED: begin
          if (cmd_fire) begin
            case (cmd_op)
              OP_RUN: begin
                state      <= S_RUN;
                halt_cause <= CAUSE_CMD;
              end
              OP_STEP: begin
                // A zero-length step is accepted but does nothing.
                if (step_arg != '0) begin
                  state      <= S_STEP;
                  step_left  <= step_arg;
                  halt_cause <= CAUSE_CMD;
                end
              end
              default: ;
            endcase
          end
        end

        S_RUN: begin
          if (hit_brk) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_BRK;
          end else if (hit_bp) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_BP;
          end else if (cmd_fire && (cmd_op == OP_HALT)) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_CMD;
          end
        end

        S_STEP: begin
          if (hit_brk) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_BRK;
            step_left  <= '0;
          end else if (cmd_fire && (cmd_op == OP_HALT)) begin
            // An instruction enabled on this edge still commits; only the
            // remaining steps are abandoned.
            state      <= S_HALTED;
            halt_cause <= CAUSE_CMD;
            step_left  <= '0;
          end else if (cpu_en) begin
            step_left <= step_left - 1'b1;
            if (step_left == STEP_W'(1)) begin
              state      <= S_HALTED;
              halt_cause <= CAUSE_STEP;
            end
          end
        end

        default: state <= S_RESET_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl with a behavioural run model
module tb_cpu_run_ctrl;

  localparam int          STEP_W     = 16;
  localparam int          RST_CYCLES = 4;
  localparam logic [31:0] BRK        = 32'h0000000D;
  localparam logic [31:0] BASE       = 32'h00400000;

  localparam logic [1:0] OP_RUN = 2'b00, OP_STEP = 2'b01, OP_HALT = 2'b10, OP_SET_BP = 2'b11;

  // Model run modes, named after the host-visible state numbers.
  localparam int M_HOLD = 0, M_HALTED = 1, M_RUN = 2, M_STEP = 3;

  logic              clk_in = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [31:0]       cmd_arg;
  logic [31:0]       pc_i;
  logic [31:0]       inst_i;
  logic              cpu_rst;
  logic              cpu_en;
  logic [1:0]        state_o;
  logic [1:0]        halt_cause;
  logic [STEP_W-1:0] step_left;
  logic [31:0]       retired_cnt;

  cpu_run_ctrl #(
    .STEP_W(STEP_W), .RST_CYCLES(RST_CYCLES), .AUTO_RUN(0), .BREAK_INST(BRK)
  ) dut (
    .clk_in(clk_in), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc_i(pc_i), .inst_i(inst_i),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .state_o(state_o), .halt_cause(halt_cause),
    .step_left(step_left), .retired_cnt(retired_cnt)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the host should observe, plus a trivial core that
  // walks straight-line code through a 64-word program memory.
  bit          m_known = 0;
  int          m_mode;
  int          m_hold;
  int          m_cause;
  int          m_steps;
  logic [31:0] m_ret;
  logic [29:0] m_bpa;
  bit          m_bpen;
  logic [31:0] core_pc = BASE;
  logic [31:0] mem [64];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, compare against the model,
  // advance the model across the rising edge, return at the next falling edge.
  task automatic cycle(input bit rst_n, input bit v, input logic [1:0] op, input logic [31:0] arg);
    bit hb, hk, en, acc;
    int n;
    int mode_before;
    reset     = rst_n;
    cmd_valid = v;
    cmd_op    = op;
    cmd_arg   = arg;
    pc_i      = core_pc;
    inst_i    = mem[core_pc[7:2]];
    #1;
    hb  = m_bpen && (core_pc[31:2] == m_bpa);
    hk  = (inst_i == BRK);
    en  = (m_mode == M_RUN && !hb && !hk) || (m_mode == M_STEP && m_steps > 0 && !hk);
    acc = v && (m_mode != M_HOLD);
    n   = int'(arg[STEP_W-1:0]);
    if (m_known) begin
      check_val("state",     32'(state_o),     32'(m_mode));
      check_val("cpu_rst",   32'(cpu_rst),     32'(m_mode == M_HOLD));
      check_val("cpu_en",    32'(cpu_en),      32'(en));
      check_val("cmd_ready", 32'(cmd_ready),   32'(m_mode != M_HOLD));
      check_val("cause",     32'(halt_cause),  32'(m_cause));
      check_val("step_left", 32'(step_left),   32'(m_steps));
      check_val("retired",   retired_cnt,      m_ret);
    end
    mode_before = m_mode;
    if (!rst_n) begin
      m_known = 1; m_mode = M_HOLD; m_hold = 0; m_cause = 0; m_steps = 0;
      m_ret = 0; m_bpa = 0; m_bpen = 0;
    end else if (m_known) begin
      if (en) m_ret = m_ret + 1;
      if (acc && op == OP_SET_BP) begin
        m_bpa = arg[31:2]; m_bpen = arg[0];
      end
      case (m_mode)
        M_HOLD: begin
          m_hold++;
          if (m_hold == RST_CYCLES) m_mode = M_HALTED;
        end
        M_HALTED: begin
          if (acc && op == OP_RUN) begin
            m_mode = M_RUN; m_cause = 0;
          end else if (acc && op == OP_STEP && n != 0) begin
            m_mode = M_STEP; m_steps = n; m_cause = 0;
          end
        end
        M_RUN: begin
          if (hk)                      begin m_mode = M_HALTED; m_cause = 2; end
          else if (hb)                 begin m_mode = M_HALTED; m_cause = 1; end
          else if (acc && op == OP_HALT) begin m_mode = M_HALTED; m_cause = 0; end
        end
        default: begin
          if (hk)                        begin m_mode = M_HALTED; m_cause = 2; m_steps = 0; end
          else if (acc && op == OP_HALT) begin m_mode = M_HALTED; m_cause = 0; m_steps = 0; end
          else if (en) begin
            m_steps--;
            if (m_steps == 0) begin m_mode = M_HALTED; m_cause = 3; end
          end
        end
      endcase
    end
    // Core: held at the reset vector while cpu_rst is high, else advances on commit.
    if (m_known && mode_before == M_HOLD) core_pc = BASE;
    else if (en) core_pc = core_pc + 32'd4;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, OP_RUN, 0);
  endtask

  task automatic do_reset();
    cycle(0, 0, OP_RUN, 0);
    for (int i = 0; i < RST_CYCLES; i++) begin
      check_val("hold_ready", 32'(cmd_ready), 32'd0);
      cycle(1, 1, OP_RUN, 0);  // offered but must not be accepted
    end
  endtask

  task automatic wait_halt(input string tag);
    bit done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      cycle(1, 0, OP_RUN, 0);
      if (state_o == 2'd1) done = 1;
    end
    check_val({tag, "_halt_timeout"}, 32'(done), 32'd1);
  endtask

  initial begin
    int en_cnt;
    bit hit;
    logic [1:0]  op;
    logic [31:0] arg;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; pc_i = BASE; inst_i = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    @(negedge clk_in);

    // Power-up hold: reset low 3 cycles, then RST_CYCLES edges of cpu_rst.
    repeat (3) cycle(0, 0, OP_RUN, 0);
    for (int i = 0; i < RST_CYCLES; i++) begin
      check_val("t1_cpu_rst_hold", 32'(cpu_rst), 32'd1);
      cycle(1, 0, OP_RUN, 0);
    end
    check_val("t1_state", 32'(state_o), 32'd1);
    check_val("t1_cpu_en", 32'(cpu_en), 32'd0);
    check_val("t1_cpu_rst", 32'(cpu_rst), 32'd0);

    // Breakpoint at 0x0040000C, then step off it.
    cycle(1, 1, OP_SET_BP, 32'h0040000D);
    cycle(1, 1, OP_RUN, 0);
    wait_halt("t2_run");
    check_val("t2_cause", 32'(halt_cause), 32'd1);
    check_val("t2_retired", retired_cnt, 32'd3);
    cycle(1, 1, OP_STEP, 32'd1);
    wait_halt("t2_step");
    check_val("t2_step_cause", 32'(halt_cause), 32'd3);
    check_val("t2_step_retired", retired_cnt, 32'd4);

    // STEP 5: exactly five commits, then STEP 0 is a no-op.
    cycle(1, 1, OP_STEP, 32'd5);
    check_val("t3_step_left_start", 32'(step_left), 32'd5);
    en_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (cpu_en) en_cnt++;
      cycle(1, 0, OP_RUN, 0);
    end
    check_val("t3_en_cycles", 32'(en_cnt), 32'd5);
    check_val("t3_cause", 32'(halt_cause), 32'd3);
    check_val("t3_step_left", 32'(step_left), 32'd0);
    cycle(1, 1, OP_STEP, 32'd0);
    check_val("t3_step0_state", 32'(state_o), 32'd1);

    // BREAK at 0x00400008 during RUN.
    mem[2] = BRK;
    do_reset();
    cycle(1, 1, OP_RUN, 0);
    wait_halt("t4_run");
    check_val("t4_cause", 32'(halt_cause), 32'd2);
    check_val("t4_retired", retired_cnt, 32'd2);
    check_val("t4_cpu_en", 32'(cpu_en), 32'd0);

    // HALT command on the breakpoint cycle: breakpoint wins.
    mem[2] = 32'h0;
    do_reset();
    cycle(1, 1, OP_SET_BP, 32'h00400011);
    cycle(1, 1, OP_RUN, 0);
    hit = 0;
    for (int i = 0; i < 32 && !hit; i++) begin
      if (core_pc == 32'h00400010) hit = 1;
      else cycle(1, 0, OP_RUN, 0);
    end
    check_val("t5_reach_bp", 32'(hit), 32'd1);
    cycle(1, 1, OP_HALT, 0);
    check_val("t5_cause", 32'(halt_cause), 32'd1);
    cycle(1, 1, OP_SET_BP, 32'h0);
    cycle(1, 1, OP_RUN, 0);
    idle(5);
    cycle(0, 0, OP_RUN, 0);
    check_val("t5_rst_state", 32'(state_o), 32'd0);
    check_val("t5_rst_retired", retired_cnt, 32'd0);
    check_val("t5_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    idle(RST_CYCLES);

    // Retired counter wrap.
    cycle(1, 1, OP_RUN, 0);
    force dut.retired_cnt = 32'hFFFFFFFF;
    #1;
    release dut.retired_cnt;
    m_ret = 32'hFFFFFFFF;
    cycle(1, 0, OP_RUN, 0);
    check_val("t6_wrap", retired_cnt, 32'd0);
    cycle(1, 1, OP_HALT, 0);

    // Randomized commands over random code with sprinkled BREAKs.
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 11) == 0) ? BRK : ($urandom | 32'h100);
    for (int c = 0; c < 3000; c++) begin
      if (m_mode == M_HALTED && mem[core_pc[7:2]] == BRK && $urandom_range(0, 3) == 0)
        mem[core_pc[7:2]] = 32'h0;
      op = 2'($urandom_range(0, 3));
      case (op)
        OP_STEP:   arg = 32'($urandom_range(0, 6));
        OP_SET_BP: arg = {BASE[31:8], 6'($urandom_range(0, 63)), 1'b0, 1'($urandom_range(0, 1))};
        default:   arg = $urandom;
      endcase
      if ($urandom_range(0, 299) == 0) cycle(0, 0, OP_RUN, 0);
      else cycle(1, ($urandom_range(0, 3) == 0), op, arg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
